// File: rtl/spi_cmd_slave_if.sv
// Byte-wide memory/register port between spi_cmd_slave (master) and the
// decoder-side storage it writes and reads (slave).
interface spi_cmd_slave_if #(
    parameter int ADDR_W = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_req, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_req, rd_addr, output rd_data);
endinterface

// File: rtl/spi_cmd_slave.sv
// SPI mode-0 command slave: WRITE/READ/STATUS frames onto a byte-wide port.
// Define SPI_READBACK_EN to build the READ (0x03) / STATUS (0x05) return path.
module spi_cmd_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_sck,
    input  logic                   spi_ss,
    input  logic                   spi_si,
    output logic                   spi_so,
    spi_cmd_slave_if.master        mem,
    input  logic [7:0]             status_in,
    output logic                   busy,
    output logic                   frame_err
);
    localparam int SL = SYNC_STAGES + 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] OPCODE = 3'd1;
    localparam logic [2:0] ADDR_H = 3'd2;
    localparam logic [2:0] ADDR_L = 3'd3;
    localparam logic [2:0] WDATA  = 3'd4;
    localparam logic [2:0] RDATA  = 3'd5;
    localparam logic [2:0] STAT   = 3'd6;
    localparam logic [2:0] IGNORE = 3'd7;

    localparam logic [7:0] OP_WRITE = 8'h02;
`ifdef SPI_READBACK_EN
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_STAT  = 8'h05;
`endif

    logic [SL-1:0]          sck_sync, ss_sync;
    logic [SYNC_STAGES-1:0] si_sync;
    logic [2:0]             state;
    logic [2:0]             bit_cnt;
    logic                   armed, is_wr;
    logic [6:0]             rx_sr;
    logic [7:0]             addr_h;
    logic [ADDR_W-1:0]      addr;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall, byte_done, addr_inc;
    logic [7:0]             rx_byte;
`ifdef SPI_READBACK_EN
    logic                   cap_tx, cap_pf, so_q, tx_active;
    logic [7:0]             tx_sr, pf_q, stat_q;
`endif

    // Edges come from the last two synchronizer stages; an extra stage holds the previous level
    always_comb begin
        sck_rise  = sck_sync[SL-2] & ~sck_sync[SL-1];
        sck_fall  = ~sck_sync[SL-2] & sck_sync[SL-1];
        ss_rise   = armed & ss_sync[SL-2] & ~ss_sync[SL-1];
        ss_fall   = armed & ~ss_sync[SL-2] & ss_sync[SL-1];
        rx_byte   = {rx_sr, si_sync[SYNC_STAGES-1]};
        byte_done = (state != IDLE) && sck_rise && (bit_cnt == 3'd7);
        addr_inc  = byte_done && (state == WDATA);
`ifdef SPI_READBACK_EN
        addr_inc  = addr_inc || cap_tx || cap_pf;
`endif
    end

    // A frame only starts after ss has been seen high since reset
    assign busy = armed & ~ss_sync[SL-2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync     <= '0;
            ss_sync      <= '0;
            si_sync      <= '0;
            armed        <= 1'b0;
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            is_wr        <= 1'b0;
            frame_err    <= 1'b0;
            mem.wr_en    <= 1'b0;
            mem.wr_addr  <= '0;
            mem.wr_data  <= 8'h00;
`ifdef SPI_READBACK_EN
            mem.rd_req   <= 1'b0;
            mem.rd_addr  <= '0;
            cap_tx       <= 1'b0;
            cap_pf       <= 1'b0;
            so_q         <= 1'b0;
`endif
        end else begin
            sck_sync  <= {sck_sync[SL-2:0], spi_sck};
            ss_sync   <= {ss_sync[SL-2:0], spi_ss};
            si_sync   <= {si_sync[SYNC_STAGES-2:0], spi_si};
            mem.wr_en <= 1'b0;
            frame_err <= 1'b0;
            if (ss_sync[SL-2])
                armed <= 1'b1;
`ifdef SPI_READBACK_EN
            mem.rd_req <= 1'b0;
            cap_tx     <= 1'b0;
            cap_pf     <= 1'b0;
            // First read byte lands in tx; its successor is prefetched right away
            if (cap_tx) begin
                cap_pf      <= 1'b1;
                mem.rd_req  <= 1'b1;
                mem.rd_addr <= addr + ADDR_W'(1);
            end
            if (tx_active && sck_fall)
                so_q <= tx_sr[7];
            if (ss_fall)
                so_q <= 1'b0;
`endif
            if (state == IDLE) begin
                if (ss_fall) begin
                    state   <= OPCODE;
                    bit_cnt <= 3'd0;
                end
            end else begin
                if (sck_rise)
                    bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    case (state)
                        OPCODE: begin
                            if (rx_byte == OP_WRITE) begin
                                is_wr <= 1'b1;
                                state <= ADDR_H;
                            end
`ifdef SPI_READBACK_EN
                            else if (rx_byte == OP_READ) begin
                                is_wr <= 1'b0;
                                state <= ADDR_H;
                            end else if (rx_byte == OP_STAT) begin
                                state <= STAT;
                            end
`endif
                            else begin
                                state <= IGNORE;
                            end
                        end
                        ADDR_H: state <= ADDR_L;
                        ADDR_L: begin
                            if (is_wr) begin
                                state <= WDATA;
                            end else begin
`ifdef SPI_READBACK_EN
                                state       <= RDATA;
                                mem.rd_req  <= 1'b1;
                                mem.rd_addr <= ADDR_W'({addr_h, rx_byte});
                                cap_tx      <= 1'b1;
`else
                                state       <= IGNORE;
`endif
                            end
                        end
                        WDATA: begin
                            mem.wr_en   <= 1'b1;
                            mem.wr_addr <= addr;
                            mem.wr_data <= rx_byte;
                        end
`ifdef SPI_READBACK_EN
                        RDATA: begin
                            mem.rd_req  <= 1'b1;
                            mem.rd_addr <= addr;
                            cap_pf      <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                // A byte completing on the same clk as ss rise still counts
                if (ss_rise) begin
                    state     <= IDLE;
                    bit_cnt   <= 3'd0;
                    frame_err <= (bit_cnt != 3'd0) && !byte_done;
                end
            end
        end
    end

    // Datapath registers: no reset, qualified entirely by control state
    always_ff @(posedge clk) begin
        if ((state != IDLE) && sck_rise)
            rx_sr <= rx_byte[6:0];
        if (byte_done && (state == ADDR_H))
            addr_h <= rx_byte;
        if (byte_done && (state == ADDR_L))
            addr <= ADDR_W'({addr_h, rx_byte});
        else if (addr_inc)
            addr <= addr + ADDR_W'(1);
`ifdef SPI_READBACK_EN
        if (cap_pf)
            pf_q <= mem.rd_data;
        if (byte_done && (state == OPCODE))
            stat_q <= status_in;
        if (cap_tx)
            tx_sr <= mem.rd_data;
        else if (byte_done && (state == OPCODE))
            tx_sr <= status_in;
        else if (byte_done && (state == RDATA))
            tx_sr <= pf_q;
        else if (byte_done && (state == STAT))
            tx_sr <= stat_q;
        else if (tx_active && sck_fall)
            tx_sr <= {tx_sr[6:0], 1'b0};
`endif
    end

`ifdef SPI_READBACK_EN
    assign tx_active = (state == RDATA) || (state == STAT);
    assign spi_so    = tx_active & so_q;
`else
    logic unused_ok;
    assign unused_ok   = ^{status_in, mem.rd_data};
    assign spi_so      = 1'b0;
    assign mem.rd_req  = 1'b0;
    assign mem.rd_addr = '0;
`endif
endmodule
